// File: rtl/fpu_sequencer.sv
// Issue/sequencing FSM for the Bfloat16 FPU; optional DIV/SQRT support under FPU_DIV_SQRT_EN.
// Latency: accept->DECODE->EXEC(L cycles or until div_done)->DONE; illegal resolves at ILLEGAL two cycles after accept.
// Backpressure: instr_ready only in IDLE, one instruction in flight; flush aborts to IDLE silently.
module fpu_sequencer #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       flush,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [2:0] instr_rm,
    input  logic [4:0] instr_rd,
    input  logic [2:0] csr_frm,
    output logic       fpu_start,
    output logic [3:0] fpu_op,
    output logic [2:0] fpu_rm,
    input  logic       div_done,
    input  logic [4:0] unit_flags,
    output logic       fpu_active,
    output logic       fpu_complete,
    output logic [4:0] S_flag,
    output logic       illegal_instr,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       halt_req
);
    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_ILLEGAL, S_DONE
    } state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt, cnt_load;
    logic [2:0]      rm_q, rm_res;
    logic            is_div, div_ill, illegal_dec, exec_fin;

    always_comb begin
        rm_res = (rm_q == 3'd7) ? csr_frm : rm_q;
        is_div = (fpu_op == 4'd3) || (fpu_op == 4'd4);
`ifdef FPU_DIV_SQRT_EN
        div_ill = 1'b0;
`else
        div_ill = is_div;
`endif
        illegal_dec = (fpu_op >= 4'd10) || (rm_res >= 3'd5) || div_ill;
        case (fpu_op)
            4'd0, 4'd1, 4'd8: cnt_load = CW'(ADD_LAT - 1);
            4'd2:             cnt_load = CW'(MUL_LAT - 1);
            default:          cnt_load = '0;
        endcase
        // DIV/SQRT only reaches EXEC when the iterative unit is built in
        exec_fin = is_div ? div_done : (cnt == '0);
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (instr_valid && instr_ready) nxt = S_DECODE;
            S_DECODE:  nxt = illegal_dec ? S_ILLEGAL : S_EXEC;
            S_EXEC:    if (exec_fin) nxt = S_DONE;
            S_ILLEGAL: nxt = S_IDLE;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (flush && state != S_IDLE) nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= S_IDLE;
            cnt           <= '0;
            rm_q          <= '0;
            instr_ready   <= 1'b0;
            fpu_start     <= 1'b0;
            fpu_op        <= '0;
            fpu_rm        <= '0;
            fpu_active    <= 1'b0;
            fpu_complete  <= 1'b0;
            S_flag        <= '0;
            illegal_instr <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            halt_req      <= 1'b0;
        end else begin
            state         <= nxt;
            instr_ready   <= (nxt == S_IDLE);
            halt_req      <= (nxt != S_IDLE);
            fpu_active    <= (nxt != S_IDLE);
            fpu_start     <= (state == S_DECODE) && (nxt == S_EXEC);
            fpu_complete  <= (nxt == S_DONE);
            wb_valid      <= (nxt == S_DONE);
            illegal_instr <= (nxt == S_ILLEGAL);
            // flags captured on the last EXEC cycle, presented only during DONE
            S_flag        <= (nxt == S_DONE) ? unit_flags : 5'd0;
            if (state == S_IDLE && nxt == S_DECODE) begin
                fpu_op <= instr_op;
                rm_q   <= instr_rm;
                wb_rd  <= instr_rd;
            end
            if (state == S_DECODE) begin
                fpu_rm <= rm_res;
                cnt    <= cnt_load;
            end
            if (state == S_EXEC && cnt != '0) cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: randomized instructions against a latency/legality model.
module tb_fpu_sequencer;
    localparam int ADD_LAT = 3;
    localparam int MUL_LAT = 4;
`ifdef FPU_DIV_SQRT_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_l = 1'b1;
    logic       flush = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = '0;
    logic [2:0] instr_rm = '0;
    logic [4:0] instr_rd = '0;
    logic [2:0] csr_frm = '0;
    logic       fpu_start;
    logic [3:0] fpu_op;
    logic [2:0] fpu_rm;
    logic       div_done = 1'b0;
    logic [4:0] unit_flags = '0;
    logic       fpu_active, fpu_complete, illegal_instr, wb_valid, halt_req;
    logic [4:0] S_flag, wb_rd;

    fpu_sequencer #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_l(rst_l), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rm(instr_rm), .instr_rd(instr_rd),
        .csr_frm(csr_frm), .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm),
        .div_done(div_done), .unit_flags(unit_flags),
        .fpu_active(fpu_active), .fpu_complete(fpu_complete), .S_flag(S_flag),
        .illegal_instr(illegal_instr), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .halt_req(halt_req)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ill;
        int         at;
        logic [4:0] rd;
        logic [4:0] flags;
        logic [2:0] rm;
        logic [3:0] op;
    } exp_t;

    exp_t cq[$];
    exp_t sq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a start, completion or illegal pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_l) begin
            if (fpu_start) begin
                if (sq.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    e = sq.pop_front();
                    chk("start_cycle", cyc, e.at);
                    chk("start_op", fpu_op, e.op);
                    chk("start_rm", fpu_rm, e.rm);
                end
            end
            if (fpu_complete || illegal_instr) begin
                if (cq.size() == 0) chk("unexpected_event", 1, 0);
                else begin
                    e = cq.pop_front();
                    chk("event_kind_illegal", illegal_instr, e.ill);
                    chk("event_cycle", cyc, e.at);
                    chk("fpu_active_at_event", fpu_active, 1);
                    if (!e.ill) begin
                        chk("wb_valid", wb_valid, 1);
                        chk("wb_rd", wb_rd, e.rd);
                        chk("S_flag", S_flag, e.flags);
                        chk("fpu_rm", fpu_rm, e.rm);
                        chk("fpu_op", fpu_op, e.op);
                    end
                end
            end else begin
                chk("S_flag_idle_zero", S_flag, 0);
                chk("wb_valid_idle_zero", wb_valid, 0);
            end
        end
    end

    // Issue one instruction; foff>0 requests a flush that many cycles after acceptance.
    task automatic issue(input logic [3:0] op, input logic [2:0] rm, input logic [4:0] rd,
                         input logic [2:0] frm, input logic [4:0] flg, input int ddlat,
                         input int foff);
        int a, lat, endc, fc, stop, w;
        logic [2:0] rres;
        bit ill, dv;
        exp_t e;
        w = 0;
        while (!instr_ready && w < 20) begin
            instr_valid = 1'b0;
            step();
            w++;
        end
        chk("ready_before_issue", instr_ready, 1);
        a = cyc;
        rres = (rm == 3'd7) ? frm : rm;
        dv = (op == 4'd3 || op == 4'd4);
        ill = (op >= 4'd10) || (rres >= 3'd5) || (dv && !DIV_EN);
        dv = dv && !ill;
        case (op)
            4'd0, 4'd1, 4'd8: lat = ADD_LAT;
            4'd2:             lat = MUL_LAT;
            4'd3, 4'd4:       lat = ddlat + 1;
            default:          lat = 1;
        endcase
        endc = ill ? a + 2 : a + 2 + lat;
        fc = -1;
        if (foff > 0) begin
            fc = a + foff;
            if (fc >= endc) fc = endc - 1;
        end
        e.ill = ill; e.at = endc; e.rd = rd; e.flags = flg; e.rm = rres; e.op = op;
        if (fc < 0) cq.push_back(e);
        if (!ill && (fc < 0 || fc >= a + 2)) begin
            e.at = a + 2;
            sq.push_back(e);
        end
        instr_valid = 1'b1; instr_op = op; instr_rm = rm; instr_rd = rd;
        flush = 1'($urandom_range(0, 1));
        csr_frm = 3'($urandom); unit_flags = 5'($urandom); div_done = 1'($urandom);
        step();
        stop = (fc >= 0) ? fc : endc;
        for (int k = a + 1; k <= stop; k++) begin
            instr_valid = 1'($urandom); instr_op = 4'($urandom);
            instr_rm = 3'($urandom); instr_rd = 5'($urandom);
            csr_frm    = (k == a + 1) ? frm : 3'($urandom);
            unit_flags = (k == endc - 1) ? flg : 5'($urandom);
            div_done   = (dv && k >= a + 2) ? (k == endc - 1) : 1'($urandom);
            flush      = (k == fc);
            step();
        end
        instr_valid = 1'b0; flush = 1'b0;
        div_done = (fc >= 0);
        chk("ready_after_instr", instr_ready, 1);
    endtask

    initial begin
        int a;
        #1 rst_l = 1'b0;
        #3;
        chk("rst_instr_ready", instr_ready, 0);
        chk("rst_fpu_active", fpu_active, 0);
        chk("rst_halt_req", halt_req, 0);
        chk("rst_outputs", {fpu_start, fpu_complete, illegal_instr, wb_valid, S_flag, wb_rd, fpu_op, fpu_rm}, 0);
        repeat (2) @(posedge clk);
        #2 rst_l = 1'b1;
        step(); step();

        issue(4'd0, 3'd0, 5'd3,  3'd0, 5'b00001, 0, 0);
        issue(4'd2, 3'd7, 5'd4,  3'd3, 5'b00100, 0, 0);
        issue(4'd2, 3'd7, 5'd5,  3'd6, 5'b00000, 0, 0);
        issue(4'd12, 3'd0, 5'd6, 3'd0, 5'b00000, 0, 0);
        issue(4'd7, 3'd1, 5'd7,  3'd0, 5'b00000, 0, 0);
        issue(4'd3, 3'd0, 5'd8,  3'd0, 5'b01000, 7, 0);
        issue(4'd4, 3'd7, 5'd9,  3'd2, 5'b10000, 0, 0);
        issue(4'd2, 3'd0, 5'd10, 3'd0, 5'b00011, 0, 3);
        issue(4'd0, 3'd4, 5'd11, 3'd0, 5'b00010, 0, 0);
        issue(4'd9, 3'd5, 5'd12, 3'd0, 5'b00000, 0, 0);

        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom), 3'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                  $urandom_range(0, 7), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0);
        end

        // asynchronous reset in the middle of a MUL: it must never complete
        while (!instr_ready) step();
        a = cyc;
        instr_valid = 1'b1; instr_op = 4'd2; instr_rm = 3'd0; instr_rd = 5'd1;
        begin
            exp_t e;
            e.ill = 0; e.at = a + 2; e.rd = 5'd1; e.flags = 0; e.rm = 3'd0; e.op = 4'd2;
            sq.push_back(e);
        end
        step();
        instr_valid = 1'b0;
        step(); step();
        #2 rst_l = 1'b0;
        #1;
        chk("midrst_instr_ready", instr_ready, 0);
        chk("midrst_fpu_active", fpu_active, 0);
        chk("midrst_halt_req", halt_req, 0);
        chk("midrst_fpu_op", fpu_op, 0);
        chk("midrst_outputs", {fpu_start, fpu_complete, illegal_instr, wb_valid, S_flag, wb_rd, fpu_rm}, 0);
        repeat (2) @(posedge clk);
        #2 rst_l = 1'b1;
        step(); step();
        chk("postrst_instr_ready", instr_ready, 1);
        chk("postrst_halt_req", halt_req, 0);
        repeat (8) step();
        chk("postrst_no_complete", fpu_complete, 0);

        issue(4'd0, 3'd2, 5'd20, 3'd0, 5'b00101, 0, 0);
        repeat (3) step();
        chk("leftover_events", cq.size(), 0);
        chk("leftover_starts", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Issue and sequencing controller for the Bfloat16 FPU datapath. It accepts one floating-point instruction at a time from decode and resolves the dynamic rounding mode against the CSR `frm` value. It launches the matching execution unit, waits out the unit's fixed or variable latency, then produces the `fpu_active`, `fpu_complete`, `S_flag` and `illegal_instr` signals consumed by the FPU CSR block, together with a writeback strobe and a core halt request.

## Interface
- `ADD_LAT`, 3: cycles for ADD/SUB/CVT (≥1)
- `MUL_LAT`, 3: cycles for MUL (≥1)
- `clk`  in  1  clock
- `rst_l`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous abort of the in-flight instruction
- `instr_valid`  in  1  decode offers an instruction
- `instr_ready`  out  1  sequencer can accept
- `instr_op`  in  4  op class: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SQRT, 5 MINMAX, 6 CMP, 7 SGNJ, 8 CVT, 9 MV; 10–15 illegal
- `instr_rm`  in  3  instruction rounding field; 3'b111 = dynamic
- `instr_rd`  in  5  destination register
- `csr_frm`  in  3  rounding mode from CSR (valid only while `fpu_active` & ~`illegal_instr`)
- `fpu_start`  out  1  one-cycle launch pulse to datapath
- `fpu_op`  out  4  latched op class
- `fpu_rm`  out  3  resolved rounding mode
- `div_done`  in  1  iterative DIV/SQRT unit finished
- `unit_flags`  in  5  exception flags from datapath {NV,DZ,OF,UF,NX}
- `fpu_active`  out  1  instruction held (DECODE..DONE)
- `fpu_complete`  out  1  one-cycle completion pulse
- `S_flag`  out  5  flags for the completing instruction
- `illegal_instr`  out  1  one-cycle illegal pulse
- `wb_valid`  out  1  writeback strobe (same cycle as `fpu_complete`)
- `wb_rd`  out  5  writeback destination
- `halt_req`  out  1  stall core; = ~IDLE

## Operation
- States: IDLE, DECODE, EXEC, ILLEGAL, DONE. All outputs and registers reset to 0; state resets to IDLE.
- IDLE: `instr_ready`=1. `instr_valid` latches op/rm/rd; next state DECODE. No other state accepts.
- DECODE: `fpu_active`=1 and `illegal_instr`=0, so the CSR drives `frm`.
  - rm resolution: `instr_rm`==7 selects `csr_frm`; otherwise `instr_rm`. The result is registered into `fpu_rm`.
  - Illegal conditions: op ≥10; resolved rm ∈ {5,6,7}; DIV/SQRT with the macro absent.
  - Illegal → ILLEGAL. Otherwise → EXEC with the counter loaded.
- Counter load:
  - `ADD_LAT`-1 for ADD/SUB/CVT.
  - `MUL_LAT`-1 for MUL.
  - 0 for MINMAX/CMP/SGNJ/MV.
  - Unused for DIV/SQRT.
- EXEC: `fpu_start`=1 on the first EXEC cycle only.
  - Fixed ops: the counter decrements each cycle. When it reaches 0, `unit_flags` is sampled and the next state is DONE.
  - DIV/SQRT: wait for `div_done`. In its cycle, `unit_flags` is sampled and the next state is DONE. `div_done` in the `fpu_start` cycle is valid.
- DONE: `fpu_complete`=1, `wb_valid`=1, `S_flag`=sampled flags, `wb_rd`=latched rd; next state IDLE. `S_flag` is 0 outside DONE.
- ILLEGAL: `illegal_instr`=1, `fpu_active`=1; no complete, no writeback; next state IDLE.
- `flush` in any non-IDLE state → IDLE next cycle, with no complete, writeback or illegal pulse. `flush` has priority over every transition. A stray `div_done` after the flush is ignored in IDLE.
- `flush` in IDLE is a no-op, and an offered instruction is still accepted.
- `div_done` or `unit_flags` outside EXEC are ignored.
- Reset mid-operation → IDLE immediately, all outputs 0.

## Timing
- Accept at edge T.
  - T+1: DECODE.
  - T+2: EXEC, `fpu_start`.
  - Fixed op of latency L: DONE at T+2+L.
  - L=1: DONE at T+3.
  - Illegal: ILLEGAL at T+2.
- Back-to-back: the next accept occurs in the cycle after DONE/ILLEGAL. Issue rate is therefore 1 instruction per L+3 cycles.
- `fpu_active` is high from DECODE through DONE inclusive, including ILLEGAL.
- `fpu_rm` and `fpu_op` are stable from EXEC entry until IDLE.

## Configuration
- `FPU_DIV_SQRT_EN` defined: DIV/SQRT are legal and sequenced via `div_done`.
- Undefined: ops 3 and 4 are treated as illegal (ILLEGAL path), and `div_done` is unused.

## Test plan
- ADD, `instr_rm`=0, `ADD_LAT`=3, `unit_flags`=5'b00001 on last EXEC → `fpu_start` at T+2; `fpu_complete`/`wb_valid` at T+5; `S_flag`=5'b00001; `fpu_rm`=0.
- MUL, `instr_rm`=7, `csr_frm`=3 → `fpu_rm`=3. Then `csr_frm`=6 → `illegal_instr` pulse at T+2, no `fpu_complete`, `instr_ready` at T+3.
- `instr_op`=12 → ILLEGAL at T+2. SGNJ → DONE at T+3 with `S_flag`=0.
- DIV with macro, `div_done` at T+9 with flags 5'b01000 → DONE at T+10, `S_flag`=5'b01000. DIV without macro → illegal at T+2.
- `flush` during MUL EXEC → IDLE next cycle, no complete/writeback. A new ADD is then accepted and completes normally.
- `rst_l` low asynchronously mid-EXEC → all outputs 0 and `instr_ready`=1 after release; the unfinished op never completes.
